// File: rtl/display_scheduler_pkg.sv
// Purpose: shared constants, FSM state type and width helper for the display scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_scheduler_pkg;

    // Digits on the physical seven-segment display; one frame scans all of them.
    localparam int DIGITS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Ceiling log2 for sizing counters and indices from integer parameters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DIG_W = clog2(DIGITS);

endpackage

// File: rtl/display_scheduler_if.sv
// Purpose: bundles requester inputs and display-side outputs of the display scheduler.
// Latency: n/a (wires only).
// Backpressure: none; requests are level-sensitive and simply wait for a frame boundary.
interface display_scheduler_if
    import display_scheduler_pkg::*;
#(
    parameter int N       = 32,
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC*N-1:0] data_in;
    logic [NUM_SRC-1:0]   hex_in;
    logic                 pause;
    logic [NUM_SRC-1:0]   grant;
    logic [N-1:0]         data_out;
    logic                 isHex_out;
    logic [DIG_W-1:0]     digit_sel;
    logic                 scan_tick;

    // Requester / display-driver side.
    modport master (
        output req, data_in, hex_in, pause,
        input  grant, data_out, isHex_out, digit_sel, scan_tick
    );

    // Scheduler side.
    modport slave (
        input  req, data_in, hex_in, pause,
        output grant, data_out, isHex_out, digit_sel, scan_tick
    );
endinterface

// File: rtl/display_scheduler_rr_pick.sv
// Purpose: combinational round-robin selector, first requester after last_owner (mod NUM_SRC).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid is low when no request bit is set.
module display_scheduler_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   pick,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest offset so the nearest requester after last_owner wins;
    // last_owner itself (offset NUM_SRC) has lowest priority.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = IDX_W'((int'(last_owner) + k) % NUM_SRC);
            if (req[cand]) begin
                pick  = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Purpose: time-shares the 8-digit display among requesters, round-robin on frame boundaries.
// Latency: grant/data registered; IDLE->SHOW one cycle after req, ownership changes only at frame end.
// Backpressure: none; waiting requesters keep req high until granted.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int N           = 32,
    parameter int NUM_SRC     = 4,
    parameter int DIV         = 50000,
    parameter int HOLD_FRAMES = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    display_scheduler_if.slave bus
);

    localparam int IDX_W  = clog2(NUM_SRC);
    localparam int PRE_W  = clog2(DIV);
    localparam int HOLD_W = clog2(HOLD_FRAMES) + 1;

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [DIG_W-1:0]   digit_q, digit_d;
    logic               tick_q, tick_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [N-1:0]       data_q, data_d;
    logic               hex_q, hex_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               frame_end;
    logic               restart;
    logic               latch_en;
    logic [IDX_W-1:0]   latch_idx;
    logic [N-1:0]       src_val [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_val[g] = bus.data_in[g*N +: N];
    end

    display_scheduler_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .last_owner (last_q),
        .pick       (pick_idx),
        .valid      (pick_vld)
    );

    // A frame ends on the tick that closes the last digit slot.
    assign frame_end = tick_q && (digit_q == DIG_LAST);

    // Digit scan: prescaler wraps at DIV-1, tick is registered so it is high while the count is DIV-1.
    always_comb begin
        presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
        digit_d = digit_q;
        if (tick_q) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end
        if (restart) begin
            presc_d = '0;
            digit_d = '0;
        end
        tick_d = (presc_d == PRE_MAX);
    end

    // Ownership FSM: decisions only on IDLE wake-up or at frame end, so a value never tears.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        last_d    = last_q;
        latch_en  = 1'b0;
        latch_idx = last_q;
        restart   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = SHOW;
                    grant_d   = NUM_SRC'(1) << pick_idx;
                    last_d    = pick_idx;
                    hold_d    = '0;
                    latch_en  = 1'b1;
                    latch_idx = pick_idx;
                    restart   = 1'b1;
                end
            end
            SHOW: begin
                if (frame_end) begin
                    if (!pick_vld) begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end else if (bus.req[last_q] && (bus.pause || (hold_q < HOLD_MAX))) begin
                        // Keep owner; the increment is guarded by hold_q < HOLD_MAX, so it saturates.
                        if (!bus.pause) begin
                            hold_d = hold_q + 1'b1;
                        end
                        latch_en  = 1'b1;
                        latch_idx = last_q;
                    end else begin
                        grant_d   = NUM_SRC'(1) << pick_idx;
                        last_d    = pick_idx;
                        hold_d    = '0;
                        latch_en  = 1'b1;
                        latch_idx = pick_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        data_d = latch_en ? src_val[latch_idx]    : data_q;
        hex_d  = latch_en ? bus.hex_in[latch_idx] : hex_q;
    end

    // State and datapath registers; last_q resets to the top index so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            digit_q <= '0;
            tick_q  <= 1'b0;
            grant_q <= '0;
            data_q  <= '0;
            hex_q   <= 1'b0;
            hold_q  <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            hex_q   <= hex_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.data_out  = data_q;
    assign bus.isHex_out = hex_q;
    assign bus.digit_sel = digit_q;
    assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Purpose: self-checking bench for display_scheduler (table vectors, corner sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_display_scheduler;

    localparam int N       = 32;
    localparam int NUM_SRC = 4;
    localparam int DIV     = 2;
    localparam int HOLD    = 3;
    localparam int FRAME   = 8 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0] src_dat [NUM_SRC];
    logic [3:0]   req_v;
    logic [3:0]   hex_v;
    logic         pause_v;

    display_scheduler_if #(.N(N), .NUM_SRC(NUM_SRC)) bus ();

    display_scheduler #(
        .N           (N),
        .NUM_SRC     (NUM_SRC),
        .DIV         (DIV),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.req    = req_v;
    assign bus.hex_in = hex_v;
    assign bus.pause  = pause_v;
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pack
        assign bus.data_in[g*N +: N] = src_dat[g];
    end

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner/hold bookkeeping plus a single position-in-frame counter.
    bit          m_idle;
    int          m_owner;
    int          m_last;
    int          m_hold;
    int          m_t;
    logic [31:0] m_data;
    logic        m_hex;

    typedef struct {
        logic [3:0]  req;
        logic        pause;
        int          cyc;
        logic [3:0]  g;
        logic [31:0] d;
        logic        h;
        logic [2:0]  dig;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_ref(input logic [3:0] r, input int last);
        for (int k = 1; k <= NUM_SRC; k++) begin
            int c;
            c = (last + k) % NUM_SRC;
            if (r[2'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_owner = 0;
        m_last  = NUM_SRC - 1;
        m_hold  = 0;
        m_t     = 0;
        m_data  = '0;
        m_hex   = 1'b0;
    endtask

    task automatic model_take(input int p);
        m_data = src_dat[2'(p)];
        m_hex  = hex_v[2'(p)];
    endtask

    task automatic model_step();
        int p;
        if (m_idle) begin
            if (req_v != 4'b0) begin
                p       = rr_ref(req_v, m_last);
                m_idle  = 1'b0;
                m_owner = p;
                m_last  = p;
                m_hold  = 0;
                model_take(p);
                m_t     = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
        end else begin
            if (m_t == FRAME - 1) begin
                if (req_v == 4'b0) begin
                    m_idle = 1'b1;
                    m_hold = 0;
                end else if (req_v[2'(m_owner)] && (pause_v || m_hold < HOLD - 1)) begin
                    if (!pause_v) m_hold++;
                    model_take(m_owner);
                end else begin
                    p       = rr_ref(req_v, m_last);
                    m_owner = p;
                    m_last  = p;
                    m_hold  = 0;
                    model_take(p);
                end
            end
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = m_idle ? 4'b0 : 4'(1 << m_owner);
        check("cycle{grant,data,hex,digit,tick}",
              64'({bus.grant, bus.data_out, bus.isHex_out, bus.digit_sel, bus.scan_tick}),
              64'({eg, m_data, m_hex, 3'(m_t / DIV), (m_t % DIV) == DIV - 1}));
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare 2 time units later.
    task automatic tick1();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #2;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    initial begin
        vecs[0] = '{4'b0001, 1'b0,  1, 4'b0001, 32'h1234_ABCD, 1'b1, 3'd0};
        vecs[1] = '{4'b0101, 1'b0, 47, 4'b0001, 32'h1234_ABCD, 1'b1, 3'd7};
        vecs[2] = '{4'b0101, 1'b0,  1, 4'b0100, 32'h2222_2222, 1'b1, 3'd0};
        vecs[3] = '{4'b0101, 1'b0, 47, 4'b0100, 32'h2222_2222, 1'b1, 3'd7};
        vecs[4] = '{4'b0101, 1'b0,  1, 4'b0001, 32'h1234_ABCD, 1'b1, 3'd0};
        vecs[5] = '{4'b0011, 1'b1, 64, 4'b0001, 32'h1234_ABCD, 1'b1, 3'd0};
        vecs[6] = '{4'b0011, 1'b0, 47, 4'b0001, 32'h1234_ABCD, 1'b1, 3'd7};
        vecs[7] = '{4'b0011, 1'b0,  1, 4'b0010, 32'h0000_1111, 1'b0, 3'd0};
        vecs[8] = '{4'b0001, 1'b0, 15, 4'b0010, 32'h0000_1111, 1'b0, 3'd7};
        vecs[9] = '{4'b0001, 1'b0,  1, 4'b0001, 32'h1234_ABCD, 1'b1, 3'd0};

        req_v      = 4'b0;
        pause_v    = 1'b0;
        hex_v      = 4'b0101;
        src_dat[0] = 32'h1234_ABCD;
        src_dat[1] = 32'h0000_1111;
        src_dat[2] = 32'h2222_2222;
        src_dat[3] = 32'h3333_3333;
        rst_n      = 1'b0;
        model_reset();

        // Reset state.
        ticks(2);
        check("rst_grant", 64'(bus.grant), 64'(0));
        check("rst_data",  64'(bus.data_out), 64'(0));
        check("rst_hex",   64'(bus.isHex_out), 64'(0));
        check("rst_digit", 64'(bus.digit_sel), 64'(0));
        check("rst_tick",  64'(bus.scan_tick), 64'(0));

        // Idle scanning: tick every 2nd clock, digit advances after each tick.
        rst_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            tick1();
            check("idle_scan", 64'({bus.digit_sel, bus.scan_tick}),
                  64'({3'((k / 2) % 8), (k % 2) == 1}));
        end
        check("idle_grant", 64'(bus.grant), 64'(0));

        // Table-driven ownership sequence.
        for (int r = 0; r < 10; r++) begin
            req_v   = vecs[r].req;
            pause_v = vecs[r].pause;
            ticks(vecs[r].cyc);
            check("tbl_grant", 64'(bus.grant), 64'(vecs[r].g));
            check("tbl_data",  64'(bus.data_out), 64'(vecs[r].d));
            check("tbl_hex",   64'(bus.isHex_out), 64'(vecs[r].h));
            check("tbl_digit", 64'(bus.digit_sel), 64'(vecs[r].dig));
        end

        // Owner 0 drops mid-frame at digit 3; its data also changes but must not appear.
        ticks(6);
        check("drop_digit", 64'(bus.digit_sel), 64'(3));
        req_v      = 4'b0010;
        src_dat[0] = 32'hDEAD_BEEF;
        tick1();
        check("drop_hold_grant", 64'(bus.grant), 64'(4'b0001));
        check("drop_hold_data",  64'(bus.data_out), 64'(32'h1234_ABCD));
        ticks(8);
        check("drop_last_digit", 64'(bus.digit_sel), 64'(7));
        check("drop_late_grant", 64'(bus.grant), 64'(4'b0001));
        check("drop_late_data",  64'(bus.data_out), 64'(32'h1234_ABCD));
        tick1();
        check("drop_new_grant", 64'(bus.grant), 64'(4'b0010));
        check("drop_new_data",  64'(bus.data_out), 64'(32'h0000_1111));
        src_dat[0] = 32'h1234_ABCD;

        // Reset pulsed mid-frame while source 2 owns the display.
        req_v = 4'b0100;
        ticks(FRAME);
        check("pre_rst_grant", 64'(bus.grant), 64'(4'b0100));
        ticks(5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_grant", 64'(bus.grant), 64'(0));
        check("mid_rst_digit", 64'(bus.digit_sel), 64'(0));
        check("mid_rst_data",  64'(bus.data_out), 64'(0));
        check("mid_rst_hex",   64'(bus.isHex_out), 64'(0));
        tick1();
        rst_n = 1'b1;
        tick1();
        check("post_rst_grant", 64'(bus.grant), 64'(4'b0100));
        check("post_rst_data",  64'(bus.data_out), 64'(32'h2222_2222));
        check("post_rst_digit", 64'(bus.digit_sel), 64'(0));

        // Randomized traffic against the model (every cycle compared inside tick1).
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0)  req_v   = 4'($urandom);
            if ($urandom_range(0, 15) == 0) pause_v = ~pause_v;
            if ($urandom_range(0, 7) == 0)  hex_v   = 4'($urandom);
            for (int i = 0; i < NUM_SRC; i++) begin
                if ($urandom_range(0, 3) == 0) src_dat[i] = $urandom;
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick1();
                rst_n = 1'b1;
            end
            tick1();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
